// File: rtl/nv_nvdla_sdp_wdma_cmd_gen_pkg.sv
// Shared SDP write-DMA definitions: command metadata layout, FSM encoding
// and the default channel atom.
package nv_nvdla_sdp_wdma_cmd_gen_pkg;

    localparam int SDP_ATOM_C = 16;

    // Command metadata, shared by both streams: spt pd is exactly this,
    // dma pd is this concatenated above the address.
    localparam int CMD_SIZE_LSB     = 0;
    localparam int CMD_SIZE_W       = 13;
    localparam int CMD_ODD_BIT      = 13;
    localparam int CMD_CUBE_END_BIT = 14;
    localparam int CMD_META_W       = 15;

    typedef struct packed {
        logic                  cube_end;
        logic                  odd;
        logic [CMD_SIZE_W-1:0] size;
    } cmd_meta_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wdma_state_e;

endpackage

// File: rtl/nv_nvdla_sdp_wdma_cmd_slot.sv
// Single-entry valid/data holding slot; the payload stays put until the
// consumer accepts it.
module nv_nvdla_sdp_wdma_cmd_slot #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         prdy_i,
    output logic         pvld_o,
    output logic [W-1:0] pd_o,
    output logic         free_o
);

    logic         pvld_q;
    logic [W-1:0] pd_q;

    // Empty, or the held entry leaves this cycle: a new one may enter.
    assign free_o = ~pvld_q | prdy_i;
    assign pvld_o = pvld_q;
    assign pd_o   = pd_q;

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pvld_q <= 1'b0;
            pd_q   <= '0;
        end else if (load_i) begin
            pvld_q <= 1'b1;
            pd_q   <= data_i;
        end else if (prdy_i) begin
            pvld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_wdma_cmd_gen.sv
// SDP write-DMA command generator: walks the output cube line by line,
// surface by surface, and issues one command per line to the dma/spt streams.
module nv_nvdla_sdp_wdma_cmd_gen
    import nv_nvdla_sdp_wdma_cmd_gen_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int ATOM_C = SDP_ATOM_C
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rstn,
    input  logic                         op_load,
    input  logic [ADDR_W-1:0]            reg2dp_dst_base_addr,
    input  logic [31:0]                  reg2dp_dst_line_stride,
    input  logic [31:0]                  reg2dp_dst_surface_stride,
    input  logic [12:0]                  reg2dp_width,
    input  logic [12:0]                  reg2dp_height,
    input  logic [12:0]                  reg2dp_channel,
    input  logic                         reg2dp_output_dst,
    output logic                         cmd2dat_dma_pvld,
    input  logic                         cmd2dat_dma_prdy,
    output logic [ADDR_W+CMD_META_W-1:0] cmd2dat_dma_pd,
    output logic                         cmd2dat_spt_pvld,
    input  logic                         cmd2dat_spt_prdy,
    output logic [CMD_META_W-1:0]        cmd2dat_spt_pd,
    output logic                         cmd_done
);

    wdma_state_e       state_q, state_d;
    logic [12:0]       width_q, width_d;
    logic [12:0]       height_q, height_d;
    logic [12:0]       surf_last_q, surf_last_d;
    logic [31:0]       line_stride_q, line_stride_d;
    logic [31:0]       surf_stride_q, surf_stride_d;
    logic              otf_q, otf_d;
    logic [12:0]       line_q, line_d;
    logic [12:0]       surf_q, surf_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [ADDR_W-1:0] surf_addr_q, surf_addr_d;

    logic      dma_free, spt_free;
    logic      load_cmd;
    logic      last_line, last_surf;
    cmd_meta_t cmd_meta;

    assign last_line = (line_q == height_q);
    assign last_surf = (surf_q == surf_last_q);

    assign cmd_meta.cube_end = last_line & last_surf;
    assign cmd_meta.odd      = ~width_q[0];
    assign cmd_meta.size     = width_q;

    // The on-the-fly path never fills the dma slot, so it never gates a load.
    assign load_cmd = (state_q == ST_RUN) & spt_free & (otf_q | dma_free);

    assign cmd_done = (state_q == ST_DRAIN) & ~cmd2dat_dma_pvld & ~cmd2dat_spt_pvld;

    always_comb begin
        // NOTE: every next-state value defaults to hold, so no path infers a latch.
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        surf_last_d   = surf_last_q;
        line_stride_d = line_stride_q;
        surf_stride_d = surf_stride_q;
        otf_d         = otf_q;
        line_d        = line_q;
        surf_d        = surf_q;
        line_addr_d   = line_addr_q;
        surf_addr_d   = surf_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (op_load) begin
                    width_d       = reg2dp_width;
                    height_d      = reg2dp_height;
                    surf_last_d   = reg2dp_channel / 13'(ATOM_C);
                    line_stride_d = reg2dp_dst_line_stride;
                    surf_stride_d = reg2dp_dst_surface_stride;
                    otf_d         = reg2dp_output_dst;
                    line_d        = '0;
                    surf_d        = '0;
                    line_addr_d   = reg2dp_dst_base_addr;
                    surf_addr_d   = reg2dp_dst_base_addr;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_cmd) begin
                    if (cmd_meta.cube_end) begin
                        state_d = ST_DRAIN;
                    end else if (last_line) begin
                        // Strides are zero-extended; the sums wrap at ADDR_W bits.
                        line_d      = '0;
                        surf_d      = surf_q + 13'd1;
                        surf_addr_d = surf_addr_q + ADDR_W'(surf_stride_q);
                        line_addr_d = surf_addr_q + ADDR_W'(surf_stride_q);
                    end else begin
                        line_d      = line_q + 13'd1;
                        line_addr_d = line_addr_q + ADDR_W'(line_stride_q);
                    end
                end
            end
            ST_DRAIN: begin
                if (cmd_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q       <= ST_IDLE;
            width_q       <= '0;
            height_q      <= '0;
            surf_last_q   <= '0;
            line_stride_q <= '0;
            surf_stride_q <= '0;
            otf_q         <= 1'b0;
            line_q        <= '0;
            surf_q        <= '0;
            line_addr_q   <= '0;
            surf_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            surf_last_q   <= surf_last_d;
            line_stride_q <= line_stride_d;
            surf_stride_q <= surf_stride_d;
            otf_q         <= otf_d;
            line_q        <= line_d;
            surf_q        <= surf_d;
            line_addr_q   <= line_addr_d;
            surf_addr_q   <= surf_addr_d;
        end
    end

    nv_nvdla_sdp_wdma_cmd_slot #(
        .W (ADDR_W + CMD_META_W)
    ) u_dma_slot (
        .clk    (nvdla_core_clk),
        .rst_n  (nvdla_core_rstn),
        .load_i (load_cmd & ~otf_q),
        .data_i ({cmd_meta, line_addr_q}),
        .prdy_i (cmd2dat_dma_prdy),
        .pvld_o (cmd2dat_dma_pvld),
        .pd_o   (cmd2dat_dma_pd),
        .free_o (dma_free)
    );

    nv_nvdla_sdp_wdma_cmd_slot #(
        .W (CMD_META_W)
    ) u_spt_slot (
        .clk    (nvdla_core_clk),
        .rst_n  (nvdla_core_rstn),
        .load_i (load_cmd),
        .data_i (cmd_meta),
        .prdy_i (cmd2dat_spt_prdy),
        .pvld_o (cmd2dat_spt_pvld),
        .pd_o   (cmd2dat_spt_pd),
        .free_o (spt_free)
    );

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_cmd_gen.sv
// Directed bench for nv_nvdla_sdp_wdma_cmd_gen; outputs are sampled on the
// falling edge, inputs are changed on the falling edge.
module tb_nv_nvdla_sdp_wdma_cmd_gen;

    localparam int ADDR_W = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_load;
    logic [63:0] base;
    logic [31:0] line_stride, surf_stride;
    logic [12:0] width, height, channel;
    logic        output_dst;
    logic        dma_pvld, dma_prdy, spt_pvld, spt_prdy, cmd_done;
    logic [78:0] dma_pd;
    logic [14:0] spt_pd;

    int tests = 0;
    int fails = 0;

    logic [78:0] dma_q[$];
    logic [14:0] spt_q[$];
    int          done_cnt, first_pvld, last_acc, done_cyc;
    logic        dma_seen;

    always #5 clk = ~clk;

    nv_nvdla_sdp_wdma_cmd_gen #(
        .ADDR_W (ADDR_W),
        .ATOM_C (16)
    ) dut (
        .nvdla_core_clk            (clk),
        .nvdla_core_rstn           (rst_n),
        .op_load                   (op_load),
        .reg2dp_dst_base_addr      (base),
        .reg2dp_dst_line_stride    (line_stride),
        .reg2dp_dst_surface_stride (surf_stride),
        .reg2dp_width              (width),
        .reg2dp_height             (height),
        .reg2dp_channel            (channel),
        .reg2dp_output_dst         (output_dst),
        .cmd2dat_dma_pvld          (dma_pvld),
        .cmd2dat_dma_prdy          (dma_prdy),
        .cmd2dat_dma_pd            (dma_pd),
        .cmd2dat_spt_pvld          (spt_pvld),
        .cmd2dat_spt_prdy          (spt_prdy),
        .cmd2dat_spt_pd            (spt_pd),
        .cmd_done                  (cmd_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [12:0] w, input logic [12:0] h, input logic [12:0] c,
                       input logic [63:0] b, input logic [31:0] ls, input logic [31:0] ss,
                       input logic dst);
        width = w; height = h; channel = c;
        base = b; line_stride = ls; surf_stride = ss; output_dst = dst;
    endtask

    // Pulses op_load, scrambles the registers right after, and records every
    // accepted command until cmd_done has been followed by a few quiet cycles.
    task automatic run_layer(input string tag, input int max_cycles);
        dma_q.delete();
        spt_q.delete();
        done_cnt = 0; first_pvld = -1; last_acc = -1; done_cyc = -1; dma_seen = 1'b0;
        @(negedge clk);
        op_load = 1'b1;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            if (c == 1) begin
                op_load = 1'b0;
                cfg(13'h1fff, 13'h0, 13'h1fff, 64'hdead_beef_0000_0000,
                    32'hffff_ffff, 32'hffff_ffff, ~output_dst);
            end
            if (dma_pvld) dma_seen = 1'b1;
            if ((dma_pvld || spt_pvld) && first_pvld < 0) first_pvld = c;
            if (spt_pvld && spt_prdy) begin spt_q.push_back(spt_pd); last_acc = c; end
            if (dma_pvld && dma_prdy) begin dma_q.push_back(dma_pd); last_acc = c; end
            if (cmd_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        check({tag, "_done_within_budget"}, done_cyc >= 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op_load = 1'b0; dma_prdy = 1'b1; spt_prdy = 1'b1;
        cfg(13'd0, 13'd0, 13'd0, 64'h0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_dma_pvld", dma_pvld, 1'b0);
        check("reset_spt_pvld", spt_pvld, 1'b0);
        check("reset_cmd_done", cmd_done, 1'b0);
        check("reset_dma_pd", dma_pd, 79'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two lines, one surface.
        cfg(13'd7, 13'd1, 13'd15, 64'h1000, 32'h100, 32'h0, 1'b0);
        run_layer("s1", 40);
        check("s1_first_pvld_cycle", first_pvld, 2);
        check("s1_dma_count", dma_q.size(), 2);
        check("s1_spt_count", spt_q.size(), 2);
        check("s1_dma0", dma_q[0], {15'h0007, 64'h1000});
        check("s1_dma1", dma_q[1], {15'h4007, 64'h1100});
        check("s1_spt0", spt_q[0], 15'h0007);
        check("s1_spt1", spt_q[1], 15'h4007);
        check("s1_done_count", done_cnt, 1);
        check("s1_done_latency", done_cyc, last_acc + 1);

        // Two surfaces of one line each.
        cfg(13'd7, 13'd0, 13'd31, 64'h2000, 32'h100, 32'h4000, 1'b0);
        run_layer("s2", 40);
        check("s2_dma_count", dma_q.size(), 2);
        check("s2_dma0", dma_q[0], {15'h0007, 64'h2000});
        check("s2_dma1", dma_q[1], {15'h4007, 64'h6000});

        // dma back-pressure while spt accepts immediately.
        cfg(13'd7, 13'd1, 13'd0, 64'h3000, 32'h100, 32'h0, 1'b0);
        dma_prdy = 1'b0;
        @(negedge clk); op_load = 1'b1;
        @(negedge clk); op_load = 1'b0;
        check("s3_no_pvld_before_load", dma_pvld | spt_pvld, 1'b0);
        @(negedge clk);
        check("s3_spt_pvld", spt_pvld, 1'b1);
        check("s3_spt_pd0", spt_pd, 15'h0007);
        check("s3_dma_pvld", dma_pvld, 1'b1);
        check("s3_dma_pd0", dma_pd, {15'h0007, 64'h3000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3_stall_dma_pvld", dma_pvld, 1'b1);
            check("s3_stall_dma_pd", dma_pd, {15'h0007, 64'h3000});
            check("s3_stall_spt_idle", spt_pvld, 1'b0);
            check("s3_stall_no_done", cmd_done, 1'b0);
        end
        dma_prdy = 1'b1;
        @(negedge clk);
        check("s3_dma_pd1", dma_pd, {15'h4007, 64'h3100});
        check("s3_spt_pvld1", spt_pvld, 1'b1);
        check("s3_spt_pd1", spt_pd, 15'h4007);
        @(negedge clk);
        check("s3_done", cmd_done, 1'b1);
        check("s3_drained", dma_pvld | spt_pvld, 1'b0);
        @(negedge clk);
        check("s3_done_pulse_ends", cmd_done, 1'b0);

        // On-the-fly: spt only.
        cfg(13'd4, 13'd3, 13'd15, 64'h8000, 32'h100, 32'h0, 1'b1);
        run_layer("s4", 40);
        check("s4_dma_never_valid", dma_seen, 1'b0);
        check("s4_dma_count", dma_q.size(), 0);
        check("s4_spt_count", spt_q.size(), 4);
        check("s4_spt0", spt_q[0], 15'h2004);
        check("s4_spt2", spt_q[2], 15'h2004);
        check("s4_spt3", spt_q[3], 15'h6004);
        check("s4_done_count", done_cnt, 1);

        // Address wrap.
        cfg(13'd7, 13'd1, 13'd0, 64'hffff_ffff_ffff_ffe0, 32'h40, 32'h0, 1'b0);
        run_layer("s5", 40);
        check("s5_dma0", dma_q[0], {15'h0007, 64'hffff_ffff_ffff_ffe0});
        check("s5_dma1_wrap", dma_q[1], {15'h4007, 64'h20});

        // Reset in the middle of a layer, then restart.
        cfg(13'd7, 13'd3, 13'd0, 64'h5000, 32'h100, 32'h0, 1'b0);
        @(negedge clk); op_load = 1'b1;
        @(negedge clk); op_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("s6_midrun_pvld", dma_pvld, 1'b1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_dma_pvld", dma_pvld, 1'b0);
        check("s6_rst_spt_pvld", spt_pvld, 1'b0);
        check("s6_rst_done", cmd_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s6_no_stale_pvld", dma_pvld | spt_pvld, 1'b0);
            check("s6_no_stale_done", cmd_done, 1'b0);
        end
        run_layer("s6", 40);
        check("s6_dma_count", dma_q.size(), 4);
        check("s6_dma0", dma_q[0], {15'h0007, 64'h5000});
        check("s6_dma3", dma_q[3], {15'h4007, 64'h5300});
        check("s6_done_count", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
